// File: rtl/irq_pending_latch.sv
// Interrupt request front end: synchronises raw request lines, latches edge-type
// requests (or follows level-type ones), masks them and feeds the priority encoder.
module irq_pending_latch #(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_in,
  input  logic [N-1:0]   edge_mode,
  input  logic [N-1:0]   mask,
  input  logic           ack_valid,
  input  logic [IDW-1:0] ack_id,
  output logic [N-1:0]   pend_vec,
  output logic           irq,
  output logic [N-1:0]   overrun
);

  logic [N-1:0] s;
  logic [N-1:0] prev_reg;
  logic [N-1:0] rise;
  logic [N-1:0] ack_hit;
  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;
  logic [N-1:0] overrun_reg;
  logic [N-1:0] overrun_next;
  logic         irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], req_in[gi]};
        end
      end

      assign s[gi]       = chain_reg[SYNC_STAGES-1];
      assign rise[gi]    = s[gi] & ~prev_reg[gi];
      assign ack_hit[gi] = ack_valid && (ack_id == IDW'(gi));

      // Set beats clear so an edge arriving with its own ack is never dropped.
      assign pending_next[gi] = edge_mode[gi]
                              ? (rise[gi] | (pending_reg[gi] & ~ack_hit[gi]))
                              : s[gi];

      assign overrun_next[gi] = edge_mode[gi]
                              & ((rise[gi] & pending_reg[gi] & ~ack_hit[gi])
                                 | (overrun_reg[gi] & ~ack_hit[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      overrun_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      prev_reg    <= s;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      irq_reg     <= |(pending_reg & mask);
    end
  end

  assign pend_vec = pending_reg & mask;
  assign irq      = irq_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed vector table, reset sequences and a
// randomized run against a sample-history reference model.
module tb_irq_pending_latch;

  localparam int N  = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_in = '0;
  logic [3:0] edge_mode = 4'b1111;
  logic [3:0] mask = 4'b1111;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_id = '0;
  logic [3:0] pend_vec;
  logic       irq;
  logic [3:0] overrun;

  int checks = 0;
  int errors = 0;

  irq_pending_latch #(.N(N), .IDW(2), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .edge_mode(edge_mode), .mask(mask),
    .ack_valid(ack_valid), .ack_id(ack_id), .pend_vec(pend_vec), .irq(irq),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] em;
    logic [3:0] msk;
    logic       av;
    logic [1:0] aid;
    logic       step;
    logic [3:0] pend;
    logic       irq;
    logic [3:0] ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [3:0] req, logic [3:0] em, logic [3:0] msk,
                             logic av, logic [1:0] aid, logic step,
                             logic [3:0] pend, logic irq_e, logic [3:0] ov);
    vec_t r;
    r.req = req; r.em = em; r.msk = msk; r.av = av; r.aid = aid; r.step = step;
    r.pend = pend; r.irq = irq_e; r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] p, input logic i, input logic [3:0] o);
    chk({nm, ".pend_vec"}, 32'(pend_vec), 32'(p));
    chk({nm, ".irq"},      32'(irq),      32'(i));
    chk({nm, ".overrun"},  32'(overrun),  32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: s seen at an edge is the input sampled SS edges earlier, prev one more.
  logic [3:0] hist[$];
  logic [3:0] m_pend, m_ov;
  logic       m_irq;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k <= SS; k++) hist.push_back(4'b0);
    m_pend = '0; m_ov = '0; m_irq = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] em, input logic [3:0] msk,
                            input logic av, input logic [1:0] aid);
    logic [3:0] s_now, s_prev, np, nov;
    s_now  = hist[1];
    s_prev = hist[0];
    m_irq  = (m_pend & msk) != 0;
    for (int i = 0; i < N; i++) begin
      bit rs = s_now[i] && !s_prev[i];
      bit ak = av && (aid == 2'(i));
      if (em[i]) begin
        np[i]  = rs ? 1'b1 : (ak ? 1'b0 : m_pend[i]);
        nov[i] = ak ? 1'b0 : ((rs && m_pend[i]) ? 1'b1 : m_ov[i]);
      end else begin
        np[i]  = s_now[i];
        nov[i] = 1'b0;
      end
    end
    m_pend = np;
    m_ov   = nov;
    void'(hist.pop_front());
    hist.push_back(r);
  endtask

  initial begin
    // Reset held with all requests high: outputs stay clear.
    req_in = 4'b1111;
    #1;
    chk_all("rst_async", 4'b0, 1'b0, 4'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("rst_hold%0d", k), 4'b0, 1'b0, 4'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("rel_edge%0d", k), (k >= 3) ? 4'b1111 : 4'b0, (k >= 4), 4'b0);
    end

    // Clean restart for the vector table.
    req_in = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();

    tbl.push_back(v(4'b0010, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0010, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0010, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 1, 1, 1, 4'b0000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b1001, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b1001, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 1, 3, 1, 4'b0001, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0001, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 1, 0, 1, 4'b0000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0100, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0100, 0, 4'b0));
    tbl.push_back(v(4'b0100, 4'hF, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 1, 2, 1, 4'b0100, 1, 4'b0));  // rise meets ack
    tbl.push_back(v(4'b0100, 4'hF, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0100, 1, 4'b0100));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 1, 2, 1, 4'b0000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'hF, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b1000, 4'h0, 4'h7, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b1000, 4'h0, 4'h7, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b1000, 4'h0, 4'h7, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b1000, 4'h0, 4'h7, 0, 0, 1, 4'b0000, 0, 4'b0));
    tbl.push_back(v(4'b1000, 4'h0, 4'hF, 0, 0, 0, 4'b1000, 0, 4'b0));  // unmask, no edge
    tbl.push_back(v(4'b1000, 4'h0, 4'hF, 0, 0, 1, 4'b1000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'h0, 4'hF, 1, 3, 1, 4'b1000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'h0, 4'hF, 1, 3, 1, 4'b1000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'h0, 4'hF, 0, 0, 1, 4'b0000, 1, 4'b0));
    tbl.push_back(v(4'b0000, 4'h0, 4'hF, 0, 0, 1, 4'b0000, 0, 4'b0));

    foreach (tbl[k]) begin
      req_in = tbl[k].req; edge_mode = tbl[k].em; mask = tbl[k].msk;
      ack_valid = tbl[k].av; ack_id = tbl[k].aid;
      if (tbl[k].step) tick();
      else #1;
      chk_all($sformatf("vec%0d", k), tbl[k].pend, tbl[k].irq, tbl[k].ov);
    end
    ack_valid = 1'b0;

    // Build pend_vec=0110 with overrun[1], then reset between clock edges.
    edge_mode = 4'hF; mask = 4'hF;
    req_in = 4'b0110; tick();
    req_in = 4'b0000; tick(); tick();
    req_in = 4'b0010; tick();
    req_in = 4'b0000; tick(); tick();
    chk_all("midop_pre", 4'b0110, 1'b1, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk_all("midop_rst", 4'b0000, 1'b0, 4'b0000);
    #1 rst = 1'b0;
    tick();
    chk_all("midop_post", 4'b0000, 1'b0, 4'b0000);

    // Randomized run against the model, from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 23 == 0) edge_mode = 4'($urandom);
      req_in    = 4'($urandom) & 4'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      ack_valid = ($urandom_range(0, 2) == 0);
      ack_id    = 2'($urandom);
      @(posedge clk);
      model_edge(req_in, edge_mode, mask, ack_valid, ack_id);
      #1;
      chk_all($sformatf("rnd%0d", c), m_pend & mask, m_irq, m_ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
